// File: rtl/spi_bus_bridge_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge: FSM encoding and
// command/response field positions derived from the bus widths.
package spi_bus_bridge_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } bridge_state_t;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 24;

    function automatic int word_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    // Command word: we at the MSB, then addr, then wdata.
    function automatic int cmd_we_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int cmd_addr_hi(input int aw, input int dw);
        return aw + dw - 1;
    endfunction

    // Response word: four status flags at the top, then the address echo.
    function automatic int resp_done_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int resp_timeout_bit(input int aw, input int dw);
        return aw + dw - 1;
    endfunction

    function automatic int resp_dropped_bit(input int aw, input int dw);
        return aw + dw - 2;
    endfunction

    function automatic int resp_frame_err_bit(input int aw, input int dw);
        return aw + dw - 3;
    endfunction

    function automatic int resp_echo_width(input int aw);
        return aw - 3;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Loadable down-counter for bus-master timeouts; saturates at zero and
// flags both the final counting cycle and the exhausted state.
module bus_timeout_counter #(
    parameter int LOAD_VALUE  = 255,
    parameter int COUNT_WIDTH = $clog2(LOAD_VALUE + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec_en,
    output logic zero,
    output logic last
);

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= COUNT_WIDTH'(LOAD_VALUE);
        end else if (dec_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == COUNT_WIDTH'(1));

endmodule

// File: rtl/spi_bus_bridge.sv
// Turns each received SPI word into one req/ack register-bus access and
// builds the status/data word the SPI slave returns in the next frame.
module spi_bus_bridge
    import spi_bus_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int WIDTH         = word_width(ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic                  system_clk,
    input  logic                  system_rst_n,
    input  logic [WIDTH-1:0]      spi_value_mosi,
    input  logic                  spi_value_valid,
    input  logic                  spi_cs_start,
    input  logic                  spi_cs_stop,
    output logic [WIDTH-1:0]      spi_value_miso,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  busy
);

    localparam int WE_BIT        = cmd_we_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int ADDR_HI       = cmd_addr_hi(ADDR_WIDTH, DATA_WIDTH);
    localparam int DONE_BIT      = resp_done_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int TIMEOUT_BIT   = resp_timeout_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int DROPPED_BIT   = resp_dropped_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int FRAME_ERR_BIT = resp_frame_err_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int ECHO_W        = resp_echo_width(ADDR_WIDTH);

    bridge_state_t state, state_next;

    logic accept;
    logic ack_done;
    logic timed_out;
    logic complete;
    logic drop_cmd;
    logic frame_short;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic cnt_last;

    logic                  resp_done;
    logic                  resp_timeout;
    logic                  resp_dropped;
    logic                  resp_frame_err;
    logic [ECHO_W-1:0]     resp_echo;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  clear_pending;

    bus_timeout_counter #(
        .LOAD_VALUE (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (system_clk),
        .rst_n  (system_rst_n),
        .load   (cnt_load),
        .dec_en (cnt_dec),
        .zero   (cnt_zero),
        .last   (cnt_last)
    );

    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timeout fires on the counter's final cycle so bus_req stays high for
    // exactly TIMEOUT_CYCLES cycles; ack takes priority over timeout.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_done   = 1'b0;
        timed_out  = 1'b0;
        drop_cmd   = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (spi_value_valid) begin
                    accept     = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_dec  = 1'b1;
                drop_cmd = spi_value_valid;
                if (bus_ack) begin
                    ack_done   = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt_last || cnt_zero) begin
                    timed_out  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign complete    = ack_done | timed_out;
    assign frame_short = spi_cs_stop & ~spi_value_valid;
    assign bus_req     = (state == ST_BUS);
    assign busy        = (state == ST_BUS);

    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (accept) begin
            bus_we    <= spi_value_mosi[WE_BIT];
            bus_addr  <= spi_value_mosi[ADDR_HI:DATA_WIDTH];
            bus_wdata <= spi_value_mosi[DATA_WIDTH-1:0];
        end
    end

    // Flags are cleared the cycle after cs_start, once the slave has captured
    // the word. A completion in the cs_start cycle is a fresh response the
    // current frame never saw, so it must not be cleared.
    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            clear_pending  <= 1'b0;
            resp_done      <= 1'b0;
            resp_timeout   <= 1'b0;
            resp_dropped   <= 1'b0;
            resp_frame_err <= 1'b0;
            resp_echo      <= '0;
            resp_data      <= '0;
        end else begin
            clear_pending <= spi_cs_start & ~complete;

            if (complete) begin
                resp_done    <= 1'b1;
                resp_timeout <= timed_out;
                resp_echo    <= bus_addr[ECHO_W-1:0];
                if (timed_out) begin
                    resp_data <= '0;
                end else if (bus_we) begin
                    resp_data <= bus_wdata;
                end else begin
                    resp_data <= bus_rdata;
                end
            end else if (clear_pending) begin
                resp_done    <= 1'b0;
                resp_timeout <= 1'b0;
            end

            if (drop_cmd) begin
                resp_dropped <= 1'b1;
            end else if (clear_pending) begin
                resp_dropped <= 1'b0;
            end

            if (frame_short) begin
                resp_frame_err <= 1'b1;
            end else if (clear_pending) begin
                resp_frame_err <= 1'b0;
            end
        end
    end

    always_comb begin
        spi_value_miso                           = '0;
        spi_value_miso[DONE_BIT]                 = resp_done;
        spi_value_miso[TIMEOUT_BIT]              = resp_timeout;
        spi_value_miso[DROPPED_BIT]              = resp_dropped;
        spi_value_miso[FRAME_ERR_BIT]            = resp_frame_err;
        spi_value_miso[FRAME_ERR_BIT-1:DATA_WIDTH] = resp_echo;
        spi_value_miso[DATA_WIDTH-1:0]           = resp_data;
    end

endmodule
